// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, runs the imem req/ack handshake and loads IF/ID.
// Absorbs memory latency, holds fetched words across stalls and squashes wrong-path fetches.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        imem_err
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t        state, state_n;
    logic [31:0]   pc, pc_n;
    logic [31:0]   instr_n, pc4_n;
    logic          valid_n, err_n;
    logic [31:0]   hold_buf, hold_buf_n;
    logic          redir_pend, redir_pend_n;
    logic [31:0]   redir_pc, redir_pc_n;
    logic [CW-1:0] wait_cnt, wait_cnt_n;

    logic          redir;
    logic [31:0]   target;
    logic [31:0]   pc_plus4;

    // Branch resolves in EX, so it is older than an ID-stage jump and takes priority.
    assign redir     = branch_taken | jump;
    assign target    = (branch_taken ? branch_target : jump_target) & ~32'd3;
    assign pc_plus4  = pc + 32'd4;
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            imem_err    <= 1'b0;
            hold_buf    <= '0;
            redir_pend  <= 1'b0;
            redir_pc    <= '0;
            wait_cnt    <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            if_id_instr <= instr_n;
            if_id_pc4   <= pc4_n;
            if_id_valid <= valid_n;
            imem_err    <= err_n;
            hold_buf    <= hold_buf_n;
            redir_pend  <= redir_pend_n;
            redir_pc    <= redir_pc_n;
            wait_cnt    <= wait_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        instr_n      = if_id_instr;
        pc4_n        = if_id_pc4;
        valid_n      = if_id_valid;
        hold_buf_n   = hold_buf;
        redir_pend_n = redir_pend;
        redir_pc_n   = redir_pc;
        wait_cnt_n   = '0;

        if (redir) valid_n = 1'b0;

        unique case (state)
            IDLE: state_n = FETCH;

            FETCH: begin
                if (imem_ack) begin
                    if (redir) begin
                        pc_n         = target;
                        redir_pend_n = 1'b0;
                    end else if (redir_pend) begin
                        // Late ack of a squashed fetch: drop the word, then head for the saved target.
                        pc_n         = redir_pc;
                        redir_pend_n = 1'b0;
                        if (!stall) valid_n = 1'b0;
                    end else if (!stall) begin
                        instr_n = imem_rdata;
                        pc4_n   = pc_plus4;
                        valid_n = 1'b1;
                        pc_n    = pc_plus4;
                    end else begin
                        hold_buf_n = imem_rdata;
                        state_n    = HOLD;
                    end
                end else begin
                    wait_cnt_n = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CW'(1);
                    if (redir) begin
                        redir_pend_n = 1'b1;
                        redir_pc_n   = target;
                    end else if (!stall) begin
                        valid_n = 1'b0;
                    end
                end
            end

            HOLD: begin
                if (redir) begin
                    pc_n    = target;
                    state_n = FETCH;
                end else if (!stall) begin
                    instr_n = hold_buf;
                    pc4_n   = pc_plus4;
                    valid_n = 1'b1;
                    pc_n    = pc_plus4;
                    state_n = FETCH;
                end
            end

            default: state_n = IDLE;
        endcase

        err_n = imem_err | (wait_cnt_n == CNT_MAX);
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a queue-based behavioural model.
module tb_fetch_sequencer;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        imem_err;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .imem_err(imem_err)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: "started" is false only in the cycle after reset; a non-empty
    // held queue means a fetched word is parked; pend_q holds the latest squashed-fetch target.
    bit          m_started;
    logic [31:0] m_pc, m_instr, m_pc4;
    bit          m_valid, m_err;
    int unsigned m_waited;
    logic [31:0] held_q[$];
    logic [31:0] pend_q[$];

    // Memory responder state
    int unsigned mem_wait, mem_lat, lat_min, lat_max;
    bit          stray_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit exp_req();
        return m_started && (held_q.size() == 0);
    endfunction

    task automatic model_reset();
        m_started = 0; m_pc = 32'h0; m_instr = '0; m_pc4 = '0;
        m_valid = 0; m_err = 0; m_waited = 0;
        held_q.delete(); pend_q.delete();
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        bit          rd;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rd  = branch_taken | jump;
        tgt = (branch_taken ? branch_target : jump_target);
        tgt[1:0] = 2'b00;
        if (rd) m_valid = 0;
        if (!m_started) begin
            m_started = 1;
        end else if (held_q.size() != 0) begin
            if (rd) begin
                held_q.delete();
                m_pc = tgt;
            end else if (!stall) begin
                m_instr = held_q.pop_front();
                m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
            end
        end else if (imem_ack) begin
            m_waited = 0;
            if (rd) begin
                pend_q.delete();
                m_pc = tgt;
            end else if (pend_q.size() != 0) begin
                m_pc = pend_q.pop_front();
                if (!stall) m_valid = 0;
            end else if (!stall) begin
                m_instr = imem_rdata;
                m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
            end else begin
                held_q.push_back(imem_rdata);
            end
        end else begin
            if (m_waited < TO) m_waited++;
            if (m_waited == TO) m_err = 1;
            if (rd) begin
                pend_q.delete();
                pend_q.push_back(tgt);
            end else if (!stall) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic check_all();
        check("imem_req",    {31'd0, imem_req},    {31'd0, exp_req()});
        check("imem_addr",   imem_addr,            m_pc);
        check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        check("if_id_instr", if_id_instr,          m_instr);
        check("if_id_pc4",   if_id_pc4,            m_pc4);
        check("imem_err",    {31'd0, imem_err},    {31'd0, m_err});
    endtask

    // One clock: present memory response, clock, advance model, compare #1 after the edge.
    task automatic cycle();
        bit was_req;
        was_req    = exp_req();
        imem_ack   = (was_req && mem_wait >= mem_lat) || stray_ack;
        imem_rdata = imem_ack ? m_pc : $urandom;
        @(posedge clk);
        model_step();
        if (!rst_n) begin
            mem_wait = 0; mem_lat = $urandom_range(lat_max, lat_min);
        end else if (was_req && imem_ack) begin
            mem_wait = 0; mem_lat = $urandom_range(lat_max, lat_min);
        end else if (was_req) begin
            mem_wait++;
        end
        #1;
        check_all();
        branch_taken = 0; jump = 0;
    endtask

    task automatic set_lat(input int unsigned lo, input int unsigned hi);
        lat_min = lo; lat_max = hi;
    endtask

    function automatic logic [31:0] rand_target();
        case ($urandom_range(3, 0))
            0:       return 32'hFFFF_FFFC;
            1:       return $urandom_range(255, 0);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        model_reset();
        stray_ack = 0;
        set_lat(0, 0); mem_lat = 0; mem_wait = 0;

        // Reset and zero-wait streaming
        rst_n = 0; cycle(); cycle();
        rst_n = 1;
        repeat (6) cycle();

        // Stall spanning an ack, then release
        stall = 1; repeat (3) cycle();
        stall = 0; repeat (3) cycle();

        // Fixed 2-cycle latency
        set_lat(2, 2); repeat (9) cycle();

        // Branch and jump together while a fetch is pending
        cycle();
        branch_taken = 1; branch_target = 32'h40;
        jump = 1; jump_target = 32'h80;
        repeat (6) cycle();

        // Redirect while holding under stall, to the top of the address space
        set_lat(0, 0);
        stall = 1; repeat (2) cycle();
        jump = 1; jump_target = 32'hFFFF_FFFE;
        cycle();
        stall = 0; repeat (4) cycle();

        // Randomized traffic
        set_lat(0, 3);
        repeat (600) begin
            stall = ($urandom_range(9, 0) < 3);
            branch_taken = ($urandom_range(15, 0) == 0);
            branch_target = rand_target();
            jump = ($urandom_range(15, 0) == 0);
            jump_target = rand_target();
            rst_n = ($urandom_range(199, 0) != 0);
            cycle();
        end
        stall = 0; rst_n = 1;

        // Memory that never answers: sticky error, then reset mid-wait with stray acks
        set_lat(1000, 1000);
        rst_n = 0; cycle();
        rst_n = 1; repeat (8) cycle();
        set_lat(0, 3);
        stray_ack = 1; rst_n = 0; cycle();
        rst_n = 1; cycle();
        stray_ack = 0; repeat (6) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-stage controller for the pipelined MIPS core: owns the program counter, drives the instruction-memory request/acknowledge handshake, selects the next PC (sequential, taken branch, jump), and loads the IF/ID pipeline register. It absorbs variable instruction-memory latency, holds fetched instructions across hazard-unit stalls and squashes wrong-path fetches on redirect. Sits between the hazard/branch logic in ID/EX and the instruction memory.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- TIMEOUT, 16, cycles a request may wait for imem_ack before imem_err sets (≥1)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
- stall  in  1  hazard unit: freeze IF/ID and PC
- branch_taken  in  1  EX-stage branch resolved taken (single-cycle pulse)
- branch_target  in  32  branch destination
- jump  in  1  ID-stage jump (single-cycle pulse)
- jump_target  in  32  jump destination
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  byte address of fetch (= pc)
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  fetched instruction
- if_id_instr  out  32  IF/ID instruction
- if_id_pc4  out  32  IF/ID PC+4
- if_id_valid  out  1  IF/ID holds a real instruction
- imem_err  out  1  sticky: request exceeded TIMEOUT

## Operation
- States: IDLE (entered only by reset), FETCH, HOLD.
- IDLE: imem_req=0; next cycle → FETCH.
- FETCH: imem_req=1, imem_addr=pc. Request held stable until imem_ack; never withdrawn.
- Redirect = branch_taken | jump; target = branch_target if branch_taken (older instruction wins), else jump_target; target[1:0] forced to 00.
- Redirect in any state: if_id_valid←0 next edge (flush, overrides stall).
  - FETCH with ack same cycle: rdata discarded, pc←target, stay FETCH.
  - FETCH without ack: redir_pend←1, redir_pc←target; pc unchanged (addr stable). On the later ack: data discarded, pc←redir_pc, redir_pend←0. A second redirect while pending overwrites redir_pc.
  - HOLD: buffer dropped, pc←target, → FETCH.
- FETCH, ack, no redirect, no redir_pend:
  - stall=0: if_id_instr←rdata, if_id_pc4←pc+4, if_id_valid←1, pc←pc+4.
  - stall=1: hold_buf←rdata, → HOLD; IF/ID unchanged.
- FETCH, no ack, stall=0: if_id_valid←0 (bubble). stall=1: IF/ID unchanged.
- HOLD: imem_req=0. When stall=0: IF/ID←{hold_buf, pc+4, 1}, pc←pc+4, → FETCH.
- PC arithmetic mod 2^32: 32'hFFFF_FFFC + 4 → 0.
- Wait counter: clears on ack or leaving FETCH; increments each FETCH cycle without ack; when it reaches TIMEOUT, imem_err←1 (sticky until reset). Counting saturates; fetch continues waiting.

## Timing
- Reset (rst_n=0 at edge): state=IDLE, pc=RESET_PC, imem_req=0, if_id_instr=0, if_id_pc4=0, if_id_valid=0, imem_err=0, redir_pend=0, counter=0. Applies mid-transaction: an outstanding request is abandoned; a late ack in IDLE is ignored.
- First imem_req one cycle after rst_n rises.
- imem_req/imem_addr are registered state decodes; ack sampled at the rising edge while imem_req=1. Zero-wait memory (ack with req) yields one instruction per cycle.
- Ack at edge N → if_id_valid/instr visible after edge N (one-cycle latency).
- Redirect at edge N with ack → imem_addr=target after edge N; first correct-path instruction in IF/ID after the edge of its ack.
- Stall released at edge N in HOLD → IF/ID loaded at edge N, new request after edge N.

## Test plan
- Reset, zero-wait memory returning addr-as-data, no hazards → imem_addr 0,4,8,12 on consecutive cycles; if_id_pc4 4,8,12; if_id_valid=1 from second cycle after reset.
- Memory with 2-cycle latency → each address held 3 cycles, if_id_valid pulses 1 of 3 cycles, counter never trips with TIMEOUT=16.
- stall=1 for 3 cycles over an ack for addr 8 → HOLD, imem_req=0, IF/ID frozen; on release IF/ID={rdata@8, 12, 1}, next imem_addr=12.
- branch_taken (target 0x40) same cycle as jump (target 0x80) during pending fetch of 0x10 → late ack data discarded, IF/ID flushed, next imem_addr=0x40.
- Redirect while in HOLD with stall=1 → flush, imem_addr=target next cycle; pc=0xFFFF_FFFC sequential → next address 0.
- ack never arrives, TIMEOUT=4 → imem_err=1 after 4 waiting cycles, stays 1; rst_n=0 mid-wait → all outputs return to reset values, stray ack ignored.
